// File: rtl/fetch_unit.sv
// SimpleRisc instruction fetch: owns the PC, issues one non-pipelined imem request at a time,
// and holds each returned word with its PC in a one-entry output register.
// Optional misaligned-redirect check under `FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic [31:0] tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst)                                  misalign_err <= 1'b0;
    else if (redirect && |redirect_pc[1:0])   misalign_err <= 1'b1;
  end
`else
  assign tgt          = redirect_pc;
  assign misalign_err = 1'b0;
`endif

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= S_REQ;
      drop        <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      // drop marks exactly one in-flight response as stale
      pc          <= tgt;
      instr_valid <= 1'b0;
      case (state)
        S_REQ: begin
          drop  <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
              state       <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            state       <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the SimpleRisc pipeline. It owns the program counter and issues one request at a time to instruction memory. It holds each returned instruction with its PC in a one-entry output register, which the immediate/branch-target stage reads. It accepts redirects (taken branch, call, ret) computed downstream and discards any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (byte address, word aligned)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  request strobe to instruction memory, one cycle per request
imem_addr  output  32  byte address of the request, valid while imem_req=1
imem_rvalid  input  1  response strobe from memory, one cycle
imem_rdata  input  32  instruction word, valid with imem_rvalid
stall  input  1  downstream not ready; holds the output register
redirect  input  1  taken branch, call or ret; one-cycle pulse
redirect_pc  input  32  new PC (btarget or return address), sampled with redirect
instr  output  32  fetched instruction word
instr_pc  output  32  PC of instr
instr_valid  output  1  instr/instr_pc hold a live instruction
misalign_err  output  1  sticky misaligned-redirect flag (optional feature; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- Reset (rst=1 at an edge):
  - pc<=RESET_PC, state<=S_REQ, drop<=0.
  - instr<=0, instr_pc<=0, instr_valid<=0, misalign_err<=0.
  - Reset mid-fetch abandons the outstanding request. A later imem_rvalid is ignored unless state is S_WAIT, and then it is treated as a normal response; the memory must be reset together with this block.
- Memory handshake:
  - Requests are non-pipelined: at most one outstanding.
  - imem_req = (state==S_REQ), combinational from state. imem_addr = pc at all times.
  - Memory answers with imem_rvalid exactly once, ≥1 cycle after the request cycle.
  - imem_rvalid is ignored in S_REQ and S_OUT.
- FSM, no redirect:
  - S_REQ: imem_req=1; next state S_WAIT.
  - S_WAIT: wait for imem_rvalid.
    - If drop=1: discard the data, drop<=0, next S_REQ.
    - Else: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), next S_OUT.
  - S_OUT: if stall=0, instr_valid<=0 and next S_REQ. If stall=1, hold all outputs and stay.
- Redirect (redirect=1), any state. Redirect has priority over stall and over a same-cycle imem_rvalid.
  - Always: pc<=redirect_pc, instr_valid<=0.
  - In S_WAIT with imem_rvalid=0: drop<=1, stay S_WAIT.
  - In S_WAIT with imem_rvalid=1: discard the data, next S_REQ.
  - In S_REQ: the request issued this cycle is stale. drop<=1, next S_WAIT.
  - In S_OUT: next S_REQ.
  - Back-to-back redirects: the last one wins. drop stays 1 until exactly one response is consumed.
- Latency: memory response L cycles after the request → instr_valid at L+1. With stall=0, one instruction per L+2 cycles.
- Acceptance: downstream takes instr at any edge where instr_valid=1 and stall=0.
- instr_pc is the exact byte PC; downstream adds the sign-extended offset×4.

Optional Feature:
Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - If redirect=1 and redirect_pc[1:0]!=0, pc is loaded with {redirect_pc[31:2],2'b00}.
  - misalign_err<=1 and stays set until rst.
  - Fetch otherwise proceeds normally.
- Undefined:
  - redirect_pc is loaded unmodified.
  - misalign_err is constant 0, and no checking logic is built.

Test Plan:
1. Reset, RESET_PC=0, memory latency 1, stall=0 → imem_req at cycles 0, 3, 6 with addr 0, 4, 8; instr_valid pulses at cycles 2, 5, 8 with instr_pc 0, 4, 8.
2. stall=1 for 4 cycles while instr_valid=1 (instr_pc=4) → instr and instr_pc stable, no imem_req issued; after stall drops, the next imem_req has addr 8.
3. redirect with redirect_pc=0x100 during S_WAIT, memory latency 3 → the old response (addr 8) is discarded with instr_valid never set; the next imem_req has addr 0x100; instr_pc=0x100.
4. redirect coincident with imem_rvalid in S_WAIT, redirect_pc=0x40 → data discarded, imem_req next cycle with addr 0x40.
5. redirect to 0xFFFF_FFFC → instr_pc=0xFFFF_FFFC, then the next fetch address is 0x0.
6. With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x102 → imem_addr=0x100 and misalign_err=1 until rst; without the macro → imem_addr=0x102 and misalign_err=0.
